// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and opcode classifiers for the RV32IM sequential ALU.
package alu_pkg;

    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_ADD    = 5'd0;
    localparam logic [OPW-1:0] OP_SUB    = 5'd1;
    localparam logic [OPW-1:0] OP_SLL    = 5'd2;
    localparam logic [OPW-1:0] OP_SLT    = 5'd3;
    localparam logic [OPW-1:0] OP_SLTU   = 5'd4;
    localparam logic [OPW-1:0] OP_XOR    = 5'd5;
    localparam logic [OPW-1:0] OP_SRL    = 5'd6;
    localparam logic [OPW-1:0] OP_SRA    = 5'd7;
    localparam logic [OPW-1:0] OP_OR     = 5'd8;
    localparam logic [OPW-1:0] OP_AND    = 5'd9;
    localparam logic [OPW-1:0] OP_MUL    = 5'd10;
    localparam logic [OPW-1:0] OP_MULH   = 5'd11;
    localparam logic [OPW-1:0] OP_MULHSU = 5'd12;
    localparam logic [OPW-1:0] OP_MULHU  = 5'd13;
    localparam logic [OPW-1:0] OP_DIV    = 5'd14;
    localparam logic [OPW-1:0] OP_DIVU   = 5'd15;
    localparam logic [OPW-1:0] OP_REM    = 5'd16;
    localparam logic [OPW-1:0] OP_REMU   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    function automatic logic op_is_mul(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic op_is_div(input logic [OPW-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_base.sv
// Single-cycle RV32I base-op unit; undefined opcodes (including M-ext codes) yield zero.
module alu_base
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [OPW-1:0]  op_i,
    output logic [XLEN-1:0] y_c
);

    logic [SHW-1:0] shamt;

    assign shamt = b_i[SHW-1:0];

    always_comb begin
        y_c = '0;
        case (op_i)
            OP_ADD:  y_c = a_i + b_i;
            OP_SUB:  y_c = a_i - b_i;
            OP_SLL:  y_c = a_i << shamt;
            OP_SLT:  y_c = XLEN'($signed(a_i) < $signed(b_i));
            OP_SLTU: y_c = XLEN'(a_i < b_i);
            OP_XOR:  y_c = a_i ^ b_i;
            OP_SRL:  y_c = a_i >> shamt;
            OP_SRA:  y_c = XLEN'($signed(a_i) >>> shamt);
            OP_OR:   y_c = a_i | b_i;
            OP_AND:  y_c = a_i & b_i;
            default: y_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_mext_seq.sv
// Multi-cycle RV32IM ALU: base ops in one cycle, MUL*/DIV*/REM* by an XLEN-step
// shift-add / restoring-division datapath on operand magnitudes, with valid/ready on both sides.
module alu_mext_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      ALUop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Y,
    output logic            zero,
    output logic            busy
);

    localparam int unsigned    PW   = 2 * XLEN;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] hi_q, lo_q, opd_q, y_q;
    logic [SHW-1:0]  cnt_q;
    logic            neg_q, rneg_q, zero_q, out_valid_q, busy_q, in_ready_q;

    logic [XLEN-1:0] base_y, fast_y, mag_a, mag_b;
    logic            accept, is_mul, is_div, div_signed, div_by0, div_ovf, div_special;
    logic            sgn_a, sgn_b;

    alu_base #(.XLEN(XLEN), .SHW(SHW)) u_base (
        .a_i  (A),
        .b_i  (B),
        .op_i (ALUop),
        .y_c  (base_y)
    );

    // Accept-time decode: operand signs, magnitudes and the division fast-path results.
    always_comb begin
        accept      = in_valid && in_ready_q;
        is_mul      = op_is_mul(ALUop);
        is_div      = op_is_div(ALUop);
        div_signed  = (ALUop == OP_DIV) || (ALUop == OP_REM);
        div_by0     = (B == '0);
        div_ovf     = div_signed && (A == SMIN) && (B == '1);
        div_special = is_div && (div_by0 || div_ovf);
        sgn_a       = A[XLEN-1] && ((ALUop == OP_MULH) || (ALUop == OP_MULHSU) || div_signed);
        sgn_b       = B[XLEN-1] && ((ALUop == OP_MULH) || div_signed);
        mag_a       = sgn_a ? (~A + XLEN'(1)) : A;
        mag_b       = sgn_b ? (~B + XLEN'(1)) : B;
        fast_y      = base_y;
        if (div_special) begin
            if (div_by0) begin
                fast_y = ((ALUop == OP_DIV) || (ALUop == OP_DIVU)) ? '1 : A;
            end else begin
                fast_y = (ALUop == OP_DIV) ? A : '0;
            end
        end
    end

    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, rem_n, quo_n, mul_y, div_y, quo_s, rem_s;
    logic [PW-1:0]   mul_prod;

    // One iteration of each datapath; {hi,lo} holds product or {remainder, quotient/dividend}.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        mul_prod = {mul_hi_n, mul_lo_n};
        if (neg_q) begin
            mul_prod = ~mul_prod + PW'(1);
        end
        mul_y = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[PW-1:XLEN];

        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opd_q};
        if (!div_diff[XLEN]) begin
            rem_n = div_diff[XLEN-1:0];
            quo_n = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_n = div_sh[XLEN-1:0];
            quo_n = {lo_q[XLEN-2:0], 1'b0};
        end
        quo_s = neg_q  ? (~quo_n + XLEN'(1)) : quo_n;
        rem_s = rneg_q ? (~rem_n + XLEN'(1)) : rem_n;
        div_y = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_s : rem_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            hi_q        <= '0;
            lo_q        <= '0;
            opd_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        op_q       <= ALUop;
                        neg_q      <= sgn_a ^ sgn_b;
                        rneg_q     <= sgn_a;
                        cnt_q      <= SHW'(XLEN - 1);
                        hi_q       <= '0;
                        if (is_mul) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                            lo_q    <= mag_b;
                            opd_q   <= mag_a;
                        end else if (is_div && !div_special) begin
                            state_q <= ST_DIV;
                            busy_q  <= 1'b1;
                            lo_q    <= mag_a;
                            opd_q   <= mag_b;
                        end else begin
                            state_q     <= ST_DONE;
                            y_q         <= fast_y;
                            zero_q      <= (fast_y == '0);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    hi_q  <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == '0) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        y_q         <= mul_y;
                        zero_q      <= (mul_y == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DIV: begin
                    hi_q  <= rem_n;
                    lo_q  <= quo_n;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == '0) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        y_q         <= div_y;
                        zero_q      <= (div_y == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_mext_seq.sv
// Scoreboard bench for alu_mext_seq: directed RV32IM cases plus randomized ops checked
// against an arithmetic reference model, with latency, busy-length and hold-stability checks.
module tb_alu_mext_seq;
    import alu_pkg::*;

    localparam logic [31:0] SMIN = 32'h8000_0000;

    typedef struct {
        logic [31:0] y;
        int          lat;
        int          busy_n;
        time         acc_t;
    } exp_t;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [31:0] A, B, Y;
    logic [4:0]  ALUop;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   hold_n = 0;

    alu_mext_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .zero      (zero),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference results straight from the RV32IM definitions using wide integer arithmetic.
    function automatic logic [31:0] ref_y(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      p;
        logic [63:0] pu;
        ia = a;
        ib = b;
        case (op)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_SLL:    return a << b[4:0];
            OP_SLT:    return (ia < ib) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:    return a ^ b;
            OP_SRL:    return a >> b[4:0];
            OP_SRA:    return 32'(ia >>> b[4:0]);
            OP_OR:     return a | b;
            OP_AND:    return a & b;
            OP_MUL:    begin pu = 64'(a) * 64'(b); return pu[31:0]; end
            OP_MULH:   begin p = longint'(ia) * longint'(ib); return p[63:32]; end
            OP_MULHSU: begin p = longint'(ia) * longint'({32'b0, b}); return p[63:32]; end
            OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == SMIN && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:   return (b == 32'd0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic bit is_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sdiv;
        sdiv = (op == OP_DIV) || (op == OP_REM);
        if (op_is_mul(op)) return 1'b1;
        if (op_is_div(op)) return (b != 32'd0) && !(sdiv && a == SMIN && b == 32'hFFFF_FFFF);
        return 1'b0;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   guard;
        guard    = 0;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        ALUop    = op;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.y      = ref_y(op, a, b);
        e.lat    = is_iter(op, a, b) ? 33 : 1;
        e.busy_n = is_iter(op, a, b) ? 32 : 0;
        e.acc_t  = $time;
        sb.push_back(e);
        #1;
        hold_n   = hold;
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        ALUop    = 5'($urandom);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return SMIN;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Consumer: random backpressure, or a forced hold on a freshly presented result.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (hold_n > 0 && out_valid) begin
                out_ready = 1'b0;
                hold_n--;
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: checks every presented result cycle against the scoreboard head.
    initial begin
        bit   seen;
        int   busy_cnt;
        int   lat;
        exp_t e;
        seen     = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen     = 1'b0;
                busy_cnt = 0;
                continue;
            end
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out_valid: got out_valid=1 with Y=0x%08h, expected no result", Y);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1'b1;
                        lat  = int'(($time - e.acc_t) / 10) + 1;
                        chk("latency", 32'(lat), 32'(e.lat));
                        chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
                    end
                    chk("Y", Y, e.y);
                    chk("zero", {31'b0, zero}, {31'b0, (e.y == 32'd0)});
                    chk("in_ready_while_valid", {31'b0, in_ready}, 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen     = 1'b0;
                        busy_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0] op;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        ALUop    = '0;
        #3;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_Y", Y, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        issue(OP_ADD, 32'h10, 32'h20, 0);
        issue(OP_SRA, SMIN, 32'd2, 0);
        issue(OP_SUB, 32'h10, 32'h10, 5);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
        issue(OP_DIVU, 32'd100, 32'd7, 0);
        issue(OP_REMU, 32'd100, 32'd7, 0);
        issue(OP_DIVU, 32'd5, 32'd0, 0);
        issue(OP_REM, 32'd5, 32'd0, 0);
        issue(OP_DIV, SMIN, 32'hFFFF_FFFF, 0);
        issue(OP_REM, SMIN, 32'hFFFF_FFFF, 0);

        // Reset in the middle of a division: result must be discarded.
        issue(OP_DIV, 32'd1000, 32'd3, 0);
        repeat (9) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_Y", Y, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        sb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("post_release_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("one_cycle_after_release_in_ready", {31'b0, in_ready}, 32'd1);
        issue(OP_ADD, 32'd1, 32'd1, 0);

        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 19));
            if (op > 5'd17) op = 5'($urandom_range(18, 31));
            issue(op, pick_operand(), pick_operand(), ($urandom_range(0, 9) == 0) ? 3 : 0);
        end

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_outstanding", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
